alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_cmd_fifo.sv | 68 ++++++
 rtl/alu_cmd_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU select encodings, flag bit indices, sequencer FSM
//               state type, command record and illegal-select check.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int C_DATA_W = 32;

    localparam logic [3:0] C_SEL_AND  = 4'b0000;
    localparam logic [3:0] C_SEL_OR   = 4'b0001;
    localparam logic [3:0] C_SEL_XOR  = 4'b0010;
    localparam logic [3:0] C_SEL_NOT  = 4'b0011;
    localparam logic [3:0] C_SEL_PASA = 4'b0100;
    localparam logic [3:0] C_SEL_PASB = 4'b0101;
    localparam logic [3:0] C_SEL_ADD  = 4'b0110;
    localparam logic [3:0] C_SEL_ADC  = 4'b0111;
    localparam logic [3:0] C_SEL_SUB  = 4'b1000;
    localparam logic [3:0] C_SEL_SBC  = 4'b1010;
    localparam logic [3:0] C_SEL_SHL  = 4'b1011;
    localparam logic [3:0] C_SEL_SHR  = 4'b1100;
    localparam logic [3:0] C_SEL_ASR  = 4'b1101;

    // Bit positions inside res_flags = {cout, neg, zero, ovf}
    localparam int C_FLAG_COUT = 3;
    localparam int C_FLAG_NEG  = 2;
    localparam int C_FLAG_ZERO = 1;
    localparam int C_FLAG_OVF  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [C_DATA_W-1:0] a;
        logic [C_DATA_W-1:0] b;
        logic [3:0]          sel;
        logic                cin;
    } alu_cmd_t;

    function automatic logic is_illegal_sel(input logic [3:0] sel);
        return !(sel inside {C_SEL_AND, C_SEL_OR, C_SEL_XOR, C_SEL_NOT,
                             C_SEL_PASA, C_SEL_PASB, C_SEL_ADD, C_SEL_ADC,
                             C_SEL_SUB, C_SEL_SBC, C_SEL_SHL, C_SEL_SHR,
                             C_SEL_ASR});
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Power-of-two deep command FIFO with occupancy count; head
//               entry is presented combinationally on pop_data.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  alu_cmd_t               push_data,
    input  logic                   pop,
    output alu_cmd_t               pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int C_AW = $clog2(DEPTH);

    alu_cmd_t          r_mem [DEPTH];
    logic [C_AW-1:0]   r_wptr;
    logic [C_AW-1:0]   r_rptr;
    logic [C_AW:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == (C_AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked solely by the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Queues ALU commands, issues them one at a time to an external
//               combinational ALU and holds each result until accepted.
//               Define ALU_SEQ_STICKY_FLAGS_EN to enable sticky {ovf,cout}.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_a,
    input  logic [31:0]            cmd_b,
    input  logic [3:0]             cmd_sel,
    input  logic                   cmd_cin,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [3:0]             alu_sel,
    output logic                   alu_cin,
    input  logic [31:0]            alu_y,
    input  logic                   alu_cout,
    input  logic                   alu_neg,
    input  logic                   alu_zero,
    input  logic                   alu_ovf,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_y,
    output logic [3:0]             res_flags,
    output logic                   res_err,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [1:0]             sticky_flags,
    input  logic                   clr_sticky
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    alu_cmd_t    r_opnd;
    logic [31:0] r_res_y;
    logic [3:0]  r_res_flags;
    logic        r_res_err;

    alu_cmd_t    w_cmd_in;
    alu_cmd_t    w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_exec;
    logic        w_res_hs;
    logic [3:0]  w_alu_flags;

    assign w_cmd_in  = '{a: cmd_a, b: cmd_b, sel: cmd_sel, cin: cmd_cin};
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_cmd_in),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // Chaining straight into EXEC gives one result every two cycles.
                if (res_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_exec  = (r_state == ST_EXEC);
    assign alu_a   = w_exec ? r_opnd.a   : '0;
    assign alu_b   = w_exec ? r_opnd.b   : '0;
    assign alu_sel = w_exec ? r_opnd.sel : '0;
    assign alu_cin = w_exec ? r_opnd.cin : 1'b0;

    always_comb begin
        w_alu_flags              = '0;
        w_alu_flags[C_FLAG_COUT] = alu_cout;
        w_alu_flags[C_FLAG_NEG]  = alu_neg;
        w_alu_flags[C_FLAG_ZERO] = alu_zero;
        w_alu_flags[C_FLAG_OVF]  = alu_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opnd      <= '0;
            r_res_y     <= '0;
            r_res_flags <= '0;
            r_res_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_opnd <= w_head;
            end
            if (w_exec) begin
                // Illegal selects still take the EXEC slot but report a clean zero.
                if (is_illegal_sel(r_opnd.sel)) begin
                    r_res_y     <= '0;
                    r_res_flags <= '0;
                    r_res_err   <= 1'b1;
                end else begin
                    r_res_y     <= alu_y;
                    r_res_flags <= w_alu_flags;
                    r_res_err   <= 1'b0;
                end
            end
        end
    end

    assign res_valid = (r_state == ST_RESP);
    assign res_y     = r_res_y;
    assign res_flags = r_res_flags;
    assign res_err   = r_res_err;
    assign w_res_hs  = res_valid && res_ready;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic [1:0] r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= '0;
        end else if (clr_sticky) begin
            r_sticky <= '0;
        end else if (w_res_hs) begin
            r_sticky <= r_sticky | {r_res_flags[C_FLAG_OVF], r_res_flags[C_FLAG_COUT]};
        end
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused_sticky;
    assign w_unused_sticky = clr_sticky & w_res_hs;
    assign sticky_flags    = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer with a behavioural
//               ALU and a queue-based reference of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_cin, res_ready, clr_sticky;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_sel;
    logic        cmd_ready, res_valid, res_err;
    logic [31:0] alu_a, alu_b, alu_y, res_y;
    logic [3:0]  alu_sel, res_flags;
    logic        alu_cin, alu_cout, alu_neg, alu_zero, alu_ovf;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [1:0]  sticky_flags;
    logic [35:0] alu_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_flags(res_flags), .res_err(res_err),
        .fifo_count(fifo_count), .sticky_flags(sticky_flags),
        .clr_sticky(clr_sticky)
    );

    // Behavioural ALU: returns {cout, neg, zero, ovf, y}; junk for illegal selects.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel, input logic cin);
        logic [32:0] s;
        logic [31:0] y;
        logic        c, v;
        c = 1'b0; v = 1'b0; y = '0; s = '0;
        case (sel)
            4'd0:  y = a & b;
            4'd1:  y = a | b;
            4'd2:  y = a ^ b;
            4'd3:  y = ~a;
            4'd4:  y = a;
            4'd5:  y = b;
            4'd6, 4'd7: begin
                s = {1'b0, a} + {1'b0, b} + ((sel == 4'd7) ? {32'd0, cin} : 33'd0);
                y = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (y[31] != a[31]);
            end
            4'd8, 4'd10: begin
                s = {1'b0, a} + {1'b0, ~b} + ((sel == 4'd8) ? 33'd1 : {32'd0, cin});
                y = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (y[31] != a[31]);
            end
            4'd11: y = a << b[4:0];
            4'd12: y = a >> b[4:0];
            4'd13: y = $unsigned($signed(a) >>> b[4:0]);
            default: return {4'hF, a ^ b ^ 32'h5A5A_5A5A};
        endcase
        return {c, y[31], (y == 32'd0), v, y};
    endfunction

    // Expected result record: {err, cout, neg, zero, ovf, y}
    function automatic logic [36:0] exp_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel, input logic cin);
        if (sel == 4'd9 || sel == 4'd14 || sel == 4'd15) return {1'b1, 36'd0};
        return {1'b0, alu_fn(a, b, sel, cin)};
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_a, alu_b, alu_sel, alu_cin);
    assign alu_y    = alu_out[31:0];
    assign alu_ovf  = alu_out[32];
    assign alu_zero = alu_out[33];
    assign alu_neg  = alu_out[34];
    assign alu_cout = alu_out[35];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic cin, output bit ok);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_cin = cin; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        ok = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        ok = res_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        checks++; if (fifo_count !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        checks++; if ({alu_a, alu_b, alu_sel, alu_cin} !== '0) begin failures++; $display("FAIL reset_alu got a=%h b=%h sel=%h want 0", alu_a, alu_b, alu_sel); end
        checks++; if ({res_y, res_flags, res_err, sticky_flags} !== '0) begin failures++; $display("FAIL reset_result got y=%h f=%b e=%b s=%b want 0", res_y, res_flags, res_err, sticky_flags); end
        rst = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_single_add();
        cmd_a = 32'd5; cmd_b = 32'd3; cmd_sel = 4'b0110; cmd_cin = 1'b0; cmd_valid = 1'b1;
        res_ready = 1'b0;
        tick();                             // edge t: accepted
        cmd_valid = 1'b0;
        checks++; if (res_valid !== 1'b0 || fifo_count !== 1) begin failures++; $display("FAIL add_t0 got valid=%b count=%0d want 0/1", res_valid, fifo_count); end
        tick();                             // edge t+1: EXEC
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL add_t1_valid got=%b want=0", res_valid); end
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_sel !== 4'b0110 || alu_cin !== 1'b0) begin failures++; $display("FAIL add_exec_operands got a=%h b=%h sel=%b want 5/3/0110", alu_a, alu_b, alu_sel); end
        tick();                             // edge t+2: result visible at t+3
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL add_latency got valid=%b want=1", res_valid); end
        checks++; if (res_y !== 32'd8 || res_flags !== 4'b0000 || res_err !== 1'b0) begin failures++; $display("FAIL add_result got y=%h f=%b e=%b want 8/0000/0", res_y, res_flags, res_err); end
        checks++; if (alu_a !== '0 || alu_sel !== '0) begin failures++; $display("FAIL add_alu_idle got a=%h sel=%b want 0", alu_a, alu_sel); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL add_after_hs got valid=%b want=0", res_valid); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [1:0] want;
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        issue(32'h7FFF_FFFF, 32'd1, 4'b0110, 1'b0, ok);
        wait_valid(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got valid=0 want=1"); end
        checks++; if (res_y !== 32'h8000_0000 || res_flags !== 4'b0101 || res_err !== 1'b0) begin failures++; $display("FAIL ovf_result got y=%h f=%b e=%b want 80000000/0101/0", res_y, res_flags, res_err); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        want = 2'b10;
`else
        want = 2'b00;
`endif
        checks++; if (sticky_flags !== want) begin failures++; $display("FAIL ovf_sticky got=%b want=%b", sticky_flags, want); end
        issue(32'hFFFF_FFFF, 32'd1, 4'b0110, 1'b0, ok);
        wait_valid(ok);
        checks++; if (res_y !== 32'd0 || res_flags !== 4'b1010) begin failures++; $display("FAIL cout_result got y=%h f=%b want 0/1010", res_y, res_flags); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        want = 2'b11;
`endif
        checks++; if (sticky_flags !== want) begin failures++; $display("FAIL cout_sticky got=%b want=%b", sticky_flags, want); end
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        checks++; if (sticky_flags !== 2'b00) begin failures++; $display("FAIL sticky_clear got=%b want=00", sticky_flags); end
        issue(32'h7FFF_FFFF, 32'd1, 4'b0110, 1'b0, ok);
        wait_valid(ok);
        res_ready = 1'b1; clr_sticky = 1'b1; tick(); res_ready = 1'b0; clr_sticky = 1'b0;
        checks++; if (sticky_flags !== 2'b00) begin failures++; $display("FAIL sticky_clear_wins got=%b want=00", sticky_flags); end
    endtask

    task automatic test_illegal();
        bit ok;
        logic [3:0] sels [3] = '{4'b1111, 4'b1001, 4'b1110};
        foreach (sels[i]) begin
            issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, sels[i], 1'b1, ok);
            wait_valid(ok);
            checks++; if (!ok || res_y !== '0 || res_flags !== '0 || res_err !== 1'b1) begin failures++; $display("FAIL illegal_%b got v=%b y=%h f=%b e=%b want 1/0/0/1", sels[i], ok, res_y, res_flags, res_err); end
            res_ready = 1'b1; tick(); res_ready = 1'b0;
        end
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0110, 1'b0, ok);
        wait_valid(ok);
        checks++; if (!ok || res_y !== 32'hFFFF_FFFE || res_flags !== 4'b1100 || res_err !== 1'b0) begin failures++; $display("FAIL legal_after_illegal got y=%h f=%b e=%b want fffffffe/1100/0", res_y, res_flags, res_err); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] a, b;
        logic [3:0]  sel;
        logic [36:0] e;
        a = rand_opnd(); b = rand_opnd(); sel = 4'($urandom_range(0, 8));
        e = exp_fn(a, b, sel, 1'b1);
        issue(a, b, sel, 1'b1, ok);
        wait_valid(ok);
        for (int i = 0; i < 10; i++) begin
            checks++; if (res_valid !== 1'b1 || {res_err, res_flags, res_y} !== e) begin failures++; $display("FAIL stall_hold_%0d got v=%b r=%h want 1/%h", i, res_valid, {res_err, res_flags, res_y}, e); end
            checks++; if ({alu_a, alu_b, alu_sel, alu_cin} !== '0) begin failures++; $display("FAIL stall_alu_zero_%0d got a=%h sel=%b want 0", i, alu_a, alu_sel); end
            tick();
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        logic [36:0] q[$];
        logic [36:0] e;
        int sent = 0, got = 0, cyc = 0, last = 0;
        res_ready = 1'b1;
        while (got < N && cyc < 200) begin
            if (res_valid) begin
                e = (q.size() > 0) ? q.pop_front() : 37'h0;
                checks++; if ({res_err, res_flags, res_y} !== e) begin failures++; $display("FAIL b2b_data_%0d got=%h want=%h", got, {res_err, res_flags, res_y}, e); end
                if (got > 0) begin
                    checks++; if (cyc - last != 2) begin failures++; $display("FAIL b2b_spacing_%0d got=%0d want=2", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
            cmd_valid = (sent < N);
            cmd_a = rand_opnd(); cmd_b = rand_opnd(); cmd_sel = 4'($urandom_range(0, 15)); cmd_cin = 1'($urandom);
            if (cmd_valid && cmd_ready) begin q.push_back(exp_fn(cmd_a, cmd_b, cmd_sel, cmd_cin)); sent++; end
            tick(); cyc++;
        end
        cmd_valid = 1'b0; res_ready = 1'b0;
        checks++; if (got != N) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", got, N); end
    endtask

    task automatic test_fill();
        localparam int N = DEPTH + 2;
        logic [36:0] q[$];
        logic [36:0] e;
        logic [31:0] ca [N];
        logic [31:0] cb [N];
        logic [3:0]  cs [N];
        logic        cc [N];
        int sent = 0, got = 0, cyc = 0;
        for (int i = 0; i < N; i++) begin
            ca[i] = rand_opnd(); cb[i] = rand_opnd(); cs[i] = 4'($urandom_range(0, 15)); cc[i] = 1'($urandom);
        end
        res_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cmd_valid = (sent < N);
            if (sent < N) begin cmd_a = ca[sent]; cmd_b = cb[sent]; cmd_sel = cs[sent]; cmd_cin = cc[sent]; end
            if (cmd_valid && cmd_ready) begin q.push_back(exp_fn(cmd_a, cmd_b, cmd_sel, cmd_cin)); sent++; end
            tick();
        end
        checks++; if (sent != DEPTH + 1) begin failures++; $display("FAIL fill_accepted got=%0d want=%0d", sent, DEPTH + 1); end
        checks++; if (cmd_ready !== 1'b0 || fifo_count !== DEPTH || res_valid !== 1'b1) begin failures++; $display("FAIL fill_full got rdy=%b cnt=%0d v=%b want 0/%0d/1", cmd_ready, fifo_count, res_valid, DEPTH); end
        res_ready = 1'b1;
        while (got < N && cyc < 200) begin
            if (res_valid) begin
                e = (q.size() > 0) ? q.pop_front() : 37'h0;
                checks++; if ({res_err, res_flags, res_y} !== e) begin failures++; $display("FAIL fill_order_%0d got=%h want=%h", got, {res_err, res_flags, res_y}, e); end
                got++;
            end
            cmd_valid = (sent < N);
            if (sent < N) begin cmd_a = ca[sent]; cmd_b = cb[sent]; cmd_sel = cs[sent]; cmd_cin = cc[sent]; end
            if (cmd_valid && cmd_ready) begin q.push_back(exp_fn(cmd_a, cmd_b, cmd_sel, cmd_cin)); sent++; end
            tick(); cyc++;
        end
        cmd_valid = 1'b0; res_ready = 1'b0;
        checks++; if (got != N || q.size() != 0) begin failures++; $display("FAIL fill_drain got=%0d left=%0d want=%0d/0", got, q.size(), N); end
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic [36:0] q[$];
        logic [36:0] e;
        logic [1:0]  exp_sticky = 2'b00;
        int sent = 0, got = 0, cyc = 0;
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        while (got < N && cyc < 3000) begin
            res_ready = ($urandom_range(0, 3) != 0);
            if (res_valid && res_ready) begin
                e = (q.size() > 0) ? q.pop_front() : 37'h0;
                checks++; if ({res_err, res_flags, res_y} !== e) begin failures++; $display("FAIL rand_result_%0d got=%h want=%h", got, {res_err, res_flags, res_y}, e); end
                exp_sticky = exp_sticky | {e[32], e[35]};
                got++;
            end
            cmd_valid = (sent < N) && ($urandom_range(0, 1) == 1);
            cmd_a = rand_opnd(); cmd_b = rand_opnd(); cmd_sel = 4'($urandom_range(0, 15)); cmd_cin = 1'($urandom);
            if (cmd_valid && cmd_ready) begin q.push_back(exp_fn(cmd_a, cmd_b, cmd_sel, cmd_cin)); sent++; end
            tick(); cyc++;
        end
        cmd_valid = 1'b0; res_ready = 1'b0;
        checks++; if (got != N) begin failures++; $display("FAIL rand_timeout got=%0d want=%0d", got, N); end
`ifndef ALU_SEQ_STICKY_FLAGS_EN
        exp_sticky = 2'b00;
`endif
        checks++; if (sticky_flags !== exp_sticky) begin failures++; $display("FAIL rand_sticky got=%b want=%b", sticky_flags, exp_sticky); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a1;
        int sent = 0;
        bit stale = 1'b0;
        a1 = 32'h1234_5678;
        res_ready = 1'b0;
        for (int c = 0; c < 15; c++) begin
            cmd_valid = (sent < DEPTH + 1);
            cmd_a = (sent == 1) ? a1 : 32'(sent + 100); cmd_b = 32'd7; cmd_sel = 4'b0110; cmd_cin = 1'b0;
            if (cmd_valid && cmd_ready) sent++;
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        checks++; if (alu_a !== a1 || fifo_count !== 3) begin failures++; $display("FAIL midrst_setup got a=%h cnt=%0d want %h/3", alu_a, fifo_count, a1); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (res_valid !== 1'b0 || fifo_count !== 0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_state got v=%b cnt=%0d rdy=%b want 0/0/1", res_valid, fifo_count, cmd_ready); end
        checks++; if (res_y !== '0 || res_err !== 1'b0 || alu_a !== '0) begin failures++; $display("FAIL midrst_regs got y=%h e=%b a=%h want 0", res_y, res_err, alu_a); end
        res_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (res_valid) stale = 1'b1;
            tick();
        end
        res_ready = 1'b0;
        checks++; if (stale) begin failures++; $display("FAIL midrst_stale got=result want=none"); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_cin = 1'b0;
        res_ready = 1'b0; clr_sticky = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_add();
        test_overflow();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_fill();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
